// File: rtl/cache_controller.sv
// Direct-mapped, write-through / no-write-allocate cache controller.
// Holds the tags and valid bits; line data lives in an external block driven through cb_*.
module cache_controller #(
    parameter int BITS_DIRECT = 10,
    parameter int LINE_BITS   = 32,
    parameter int ADDR_BITS   = 32
) (
    input  logic                   clk,
    input  logic                   gen_reset,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [ADDR_BITS-1:0]   cpu_addr,
    input  logic [LINE_BITS-1:0]   cpu_wdata,
    output logic                   cpu_ready,
    output logic                   cpu_valid,
    output logic [LINE_BITS-1:0]   cpu_rdata,
    output logic                   cb_we,
    output logic                   cb_re,
    output logic [BITS_DIRECT-1:0] cb_addr,
    output logic [LINE_BITS-1:0]   cb_wdata,
    input  logic [LINE_BITS-1:0]   cb_rdata,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDR_BITS-1:0]   mem_addr,
    output logic [LINE_BITS-1:0]   mem_wdata,
    input  logic                   mem_ack,
    input  logic [LINE_BITS-1:0]   mem_rdata,
    output logic [15:0]            hit_count,
    output logic [15:0]            miss_count
);

    localparam int LINES = 1 << BITS_DIRECT;
    localparam int TAG_W = ADDR_BITS - BITS_DIRECT;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOOKUP    = 3'd1;
    localparam logic [2:0] S_FILL      = 3'd2;
    localparam logic [2:0] S_WRITE_MEM = 3'd3;
    localparam logic [2:0] S_RESP      = 3'd4;

    logic [2:0]             r_state;
    logic                   r_reqWe;
    logic [ADDR_BITS-1:0]   r_reqAddr;
    logic [LINE_BITS-1:0]   r_reqWdata;
    logic [LINE_BITS-1:0]   r_rdata;
    logic [15:0]            r_hitCount;
    logic [15:0]            r_missCount;
    logic [LINES-1:0]       r_valid;
    logic [TAG_W-1:0]       r_tag [0:LINES-1];

    logic [BITS_DIRECT-1:0] w_index;
    logic [TAG_W-1:0]       w_reqTag;
    logic                   w_hit;
    logic                   w_fillDone;

    assign w_index    = r_reqAddr[BITS_DIRECT-1:0];
    assign w_reqTag   = r_reqAddr[ADDR_BITS-1:BITS_DIRECT];
    assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_reqTag);
    assign w_fillDone = (r_state == S_FILL) && mem_ack;

    // Outputs decode straight from state so an async reset drops mem_req immediately.
    assign cpu_ready  = (r_state == S_IDLE);
    assign cpu_valid  = (r_state == S_RESP);
    assign cpu_rdata  = r_rdata;
    assign cb_addr    = w_index;
    assign cb_re      = (r_state == S_LOOKUP) && !r_reqWe && w_hit;
    assign cb_we      = ((r_state == S_LOOKUP) && r_reqWe && w_hit) || w_fillDone;
    assign cb_wdata   = (r_state == S_FILL) ? mem_rdata : r_reqWdata;
    assign mem_req    = (r_state == S_FILL) || (r_state == S_WRITE_MEM);
    assign mem_we     = (r_state == S_WRITE_MEM);
    assign mem_addr   = r_reqAddr;
    assign mem_wdata  = r_reqWdata;
    assign hit_count  = r_hitCount;
    assign miss_count = r_missCount;

    // Tag storage needs no reset; a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (w_fillDone) begin
            r_tag[w_index] <= w_reqTag;
        end
    end

    always_ff @(posedge clk or posedge gen_reset) begin
        if (gen_reset) begin
            r_state     <= S_IDLE;
            r_reqWe     <= 1'b0;
            r_reqAddr   <= '0;
            r_reqWdata  <= '0;
            r_rdata     <= '0;
            r_hitCount  <= '0;
            r_missCount <= '0;
            r_valid     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu_req) begin
                        r_reqWe    <= cpu_we;
                        r_reqAddr  <= cpu_addr;
                        r_reqWdata <= cpu_wdata;
                        r_state    <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        if (r_hitCount != 16'hFFFF) begin
                            r_hitCount <= r_hitCount + 16'd1;
                        end
                    end else if (r_missCount != 16'hFFFF) begin
                        r_missCount <= r_missCount + 16'd1;
                    end
                    if (r_reqWe) begin
                        r_state <= S_WRITE_MEM;
                    end else if (w_hit) begin
                        r_rdata <= cb_rdata;
                        r_state <= S_RESP;
                    end else begin
                        r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (mem_ack) begin
                        r_valid[w_index] <= 1'b1;
                        r_rdata          <= mem_rdata;
                        r_state          <= S_RESP;
                    end
                end
                S_WRITE_MEM: begin
                    if (mem_ack) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Randomised and directed bench for cache_controller against a line-level reference model,
// with a behavioural main memory and cache data block around the DUT.
module tb_cache_controller;

    logic        clk;
    logic        gen_reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_valid;
    logic [31:0] cpu_rdata;
    logic        cb_we;
    logic        cb_re;
    logic [9:0]  cb_addr;
    logic [31:0] cb_wdata;
    logic [31:0] cb_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int nChecks = 0;
    int nFail   = 0;

    // Reference model: which tag each line holds, its data, and the statistics.
    bit          mValid [0:1023];
    logic [21:0] mTag   [0:1023];
    logic [31:0] mData  [0:1023];
    logic [15:0] mHit;
    logic [15:0] mMiss;
    logic [31:0] mainMem [logic [31:0]];
    logic [31:0] cbArray [0:1023];

    cache_controller dut (
        .clk        (clk),
        .gen_reset  (gen_reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_valid  (cpu_valid),
        .cpu_rdata  (cpu_rdata),
        .cb_we      (cb_we),
        .cb_re      (cb_re),
        .cb_addr    (cb_addr),
        .cb_wdata   (cb_wdata),
        .cb_rdata   (cb_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream data block: written by the DUT, read back combinationally.
    always @(posedge clk) begin
        if (cb_we) cbArray[cb_addr] <= cb_wdata;
    end
    assign cb_rdata = cbArray[cb_addr];

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (mainMem.exists(a)) return mainMem[a];
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 1024; i++) mValid[i] = 1'b0;
        mHit  = '0;
        mMiss = '0;
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_hits"}, 32'(hit_count), 32'(mHit));
        checkOutput({tag, "_misses"}, 32'(miss_count), 32'(mMiss));
    endtask

    // One complete CPU transaction with the memory answering after ackDelay waiting cycles.
    task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input int ackDelay);
        int          idx;
        logic [21:0] tag;
        bit          hit;
        logic [31:0] expRdata;
        int          cyc;
        int          waitCnt;
        bit          done;
        bit          sawReq;

        idx      = int'(addr[9:0]);
        tag      = addr[31:10];
        hit      = mValid[idx] && (mTag[idx] == tag);
        expRdata = '0;
        if (hit) begin
            if (mHit != 16'hFFFF) mHit = mHit + 16'd1;
        end else if (mMiss != 16'hFFFF) begin
            mMiss = mMiss + 16'd1;
        end
        if (we) begin
            mainMem[addr] = wdata;
            if (hit) mData[idx] = wdata;
        end else begin
            if (!hit) begin
                mValid[idx] = 1'b1;
                mTag[idx]   = tag;
                mData[idx]  = memRead(addr);
            end
            expRdata = mData[idx];
        end

        @(negedge clk);
        checkOutput("ready_idle", 32'(cpu_ready), 32'd1);
        checkOutput("valid_idle", 32'(cpu_valid), 32'd0);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;

        cyc = 0; waitCnt = 0; done = 1'b0; sawReq = 1'b0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            mem_ack   = 1'b0;
            cpu_req   = 1'($urandom_range(0, 1));
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = $urandom;
            cpu_wdata = $urandom;
            if (cpu_valid) begin
                done    = 1'b1;
                cpu_req = 1'b0;
                if (!we) checkOutput("rdata", cpu_rdata, expRdata);
                if (!we && hit) checkOutput("hit_latency", 32'(cyc), 32'd2);
                checkOutput("mem_used", 32'(sawReq), 32'(we || !hit));
                checkCounters("stats");
            end else if (cyc == 1) begin
                checkOutput("lookup_re", 32'(cb_re), 32'(!we && hit));
                checkOutput("lookup_we", 32'(cb_we), 32'(we && hit));
                checkOutput("lookup_req", 32'(mem_req), 32'd0);
                if (hit) checkOutput("lookup_addr", 32'(cb_addr), 32'(idx));
                if (we && hit) checkOutput("lookup_wdata", cb_wdata, wdata);
            end else if (mem_req) begin
                if (!sawReq) begin
                    checkOutput("mem_we", 32'(mem_we), 32'(we));
                    checkOutput("mem_addr", mem_addr, addr);
                    if (we) checkOutput("mem_wdata", mem_wdata, wdata);
                end
                sawReq = 1'b1;
                waitCnt++;
                if (waitCnt > ackDelay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = we ? $urandom : memRead(addr);
                    #1;
                    checkOutput("ack_cb_we", 32'(cb_we), 32'(!we));
                    if (!we) begin
                        checkOutput("fill_addr", 32'(cb_addr), 32'(idx));
                        checkOutput("fill_wdata", cb_wdata, mem_rdata);
                    end
                end else begin
                    checkOutput("wait_cb", 32'({cb_we, cb_re}), 32'd0);
                end
            end
        end
        if (!done) checkOutput("timeout", 32'd0, 32'd1);
        mem_ack = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          k;

        for (int i = 0; i < 1024; i++) cbArray[i] = '0;
        modelReset();
        mainMem[32'h0000_0005] = 32'hCAFE_BABE;
        mainMem[32'h0000_0405] = 32'hDEAD_0405;
        gen_reset = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        repeat (3) @(negedge clk);
        gen_reset = 1'b0;
        @(negedge clk);

        checkOutput("rst_ready", 32'(cpu_ready), 32'd1);
        checkOutput("rst_valid", 32'(cpu_valid), 32'd0);
        checkOutput("rst_memreq", 32'(mem_req), 32'd0);
        checkOutput("rst_cb", 32'({cb_we, cb_re}), 32'd0);
        checkOutput("rst_rdata", cpu_rdata, 32'd0);
        checkCounters("rst");

        // Cold miss with a slow memory, then a hit on the same word.
        applyStimulus(1'b0, 32'h0000_0005, 32'h0, 3);
        checkOutput("first_rdata", cpu_rdata, 32'hCAFE_BABE);
        applyStimulus(1'b0, 32'h0000_0005, 32'h0, 0);

        // Write hit updates the line; a write miss must not allocate.
        applyStimulus(1'b1, 32'h0000_0005, 32'h1234_5678, 1);
        applyStimulus(1'b0, 32'h0000_0005, 32'h0, 0);
        applyStimulus(1'b1, 32'h0000_0009, 32'hA5A5_0009, 2);
        applyStimulus(1'b0, 32'h0000_0009, 32'h0, 0);

        // Conflict on index 5 evicts the earlier tag.
        applyStimulus(1'b0, 32'h0000_0405, 32'h0, 1);
        applyStimulus(1'b0, 32'h0000_0005, 32'h0, 0);

        // Reset while a fill is outstanding.
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0007;
        @(negedge clk);
        cpu_req = 1'b0;
        k = 0;
        while (!mem_req && k < 10) begin
            @(negedge clk);
            k++;
        end
        checkOutput("abort_req_seen", 32'(mem_req), 32'd1);
        gen_reset = 1'b1;
        #1;
        checkOutput("abort_req_drop", 32'(mem_req), 32'd0);
        checkOutput("abort_valid", 32'(cpu_valid), 32'd0);
        @(negedge clk);
        gen_reset = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        modelReset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            checkOutput("abort_no_valid", 32'({cpu_valid, mem_req}), 32'd0);
        end
        checkCounters("abort");
        applyStimulus(1'b0, 32'h0000_0007, 32'h0, 0);

        // Random traffic over a few indices and tags to mix hits, misses and evictions.
        for (int n = 0; n < 40; n++) begin
            a = (32'($urandom_range(0, 3)) << 10) | 32'($urandom_range(4, 7));
            applyStimulus(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 3)));
        end

        // Saturation of the hit counter from a preloaded value.
        applyStimulus(1'b0, 32'h0000_0005, 32'h0, 0);
        @(negedge clk);
        force dut.r_hitCount = 16'hFFFE;
        #1;
        release dut.r_hitCount;
        mHit = 16'hFFFE;
        applyStimulus(1'b0, 32'h0000_0005, 32'h0, 0);
        checkOutput("sat_reach", 32'(hit_count), 32'h0000_FFFF);
        applyStimulus(1'b0, 32'h0000_0005, 32'h0, 0);
        checkOutput("sat_hold", 32'(hit_count), 32'h0000_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule
